// File: rtl/phy_link_monitor.sv
// Periodically reads the PHY BMSR and a vendor status register over an MDIO driver and
// publishes a debounced link state together with the negotiated speed and duplex.
module phy_link_monitor #(
   parameter logic [23:0] POLL_CYCLES = 24'd1_000_000,
   parameter logic [15:0] TIMEOUT     = 16'd4096,
   parameter logic [4:0]  STAT_REG    = 5'h11,
   parameter logic [1:0]  LINK_STABLE = 2'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        poll_en,
   input  logic        op_done,
   input  logic [15:0] op_rd_data,
   input  logic        op_rd_ack,
   output logic        op_exec,
   output logic        op_rh_wl,
   output logic [4:0]  op_addr,
   output logic [15:0] op_wr_data,
   output logic        link_up,
   output logic [1:0]  speed,
   output logic        duplex,
   output logic        status_chg,
   output logic        rd_err
);

   typedef enum logic [2:0] {
      StIdle,
      StRdBmsr,
      StWaitBmsr,
      StRdStat,
      StWaitStat,
      StUpdate
   } state_e;

   state_e      state_q;
   logic [23:0] timer_q;
   logic [15:0] wait_q;
   logic [1:0]  stab_q;
   logic        link_smp_q;
   logic [1:0]  spd_smp_q;
   logic        dup_smp_q;
   logic        res_smp_q;
   logic        chg_pend_q;

   logic        link_nxt;
   logic [1:0]  stab_nxt;
   logic [1:0]  speed_nxt;
   logic        duplex_nxt;
   logic        wait_expired;

   assign op_wr_data   = 16'h0000;
   assign wait_expired = (wait_q == TIMEOUT - 16'd1);

   // Debounce the captured link sample and derive the values UPDATE will commit.
   always_comb begin
      link_nxt   = link_up;
      stab_nxt   = stab_q;
      speed_nxt  = speed;
      duplex_nxt = duplex;
      if (link_smp_q == link_up) begin
         stab_nxt = 2'd0;
      end else if (stab_q + 2'd1 >= LINK_STABLE) begin
         link_nxt = link_smp_q;
         stab_nxt = 2'd0;
      end else begin
         stab_nxt = stab_q + 2'd1;
      end
      if (!link_nxt) begin
         speed_nxt  = 2'b00;
         duplex_nxt = 1'b0;
      end else if (res_smp_q && spd_smp_q != 2'b11) begin
         speed_nxt  = spd_smp_q;
         duplex_nxt = dup_smp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         timer_q    <= 24'd0;
         wait_q     <= 16'd0;
         stab_q     <= 2'd0;
         link_smp_q <= 1'b0;
         spd_smp_q  <= 2'b00;
         dup_smp_q  <= 1'b0;
         res_smp_q  <= 1'b0;
         chg_pend_q <= 1'b0;
         op_exec    <= 1'b0;
         op_rh_wl   <= 1'b1;
         op_addr    <= 5'h00;
         link_up    <= 1'b0;
         speed      <= 2'b00;
         duplex     <= 1'b0;
         status_chg <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         op_exec    <= 1'b0;
         rd_err     <= 1'b0;
         status_chg <= chg_pend_q;
         chg_pend_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!poll_en) begin
                  timer_q <= 24'd0;
               end else if (timer_q == POLL_CYCLES - 24'd1) begin
                  // op_exec is raised on entry so it is high for the whole RD_BMSR cycle.
                  timer_q  <= 24'd0;
                  state_q  <= StRdBmsr;
                  op_exec  <= 1'b1;
                  op_rh_wl <= 1'b1;
                  op_addr  <= 5'h01;
               end else begin
                  timer_q <= timer_q + 24'd1;
               end
            end
            StRdBmsr: begin
               wait_q  <= 16'd0;
               state_q <= StWaitBmsr;
            end
            StWaitBmsr: begin
               if (op_done) begin
                  if (op_rd_ack) begin
                     rd_err  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     link_smp_q <= op_rd_data[2];
                     state_q    <= StRdStat;
                     op_exec    <= 1'b1;
                     op_rh_wl   <= 1'b1;
                     op_addr    <= STAT_REG;
                  end
               end else if (wait_expired) begin
                  rd_err  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end
            StRdStat: begin
               wait_q  <= 16'd0;
               state_q <= StWaitStat;
            end
            StWaitStat: begin
               if (op_done) begin
                  if (op_rd_ack) begin
                     rd_err  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     spd_smp_q <= op_rd_data[15:14];
                     dup_smp_q <= op_rd_data[13];
                     res_smp_q <= op_rd_data[11];
                     state_q   <= StUpdate;
                  end
               end else if (wait_expired) begin
                  rd_err  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end
            StUpdate: begin
               link_up    <= link_nxt;
               stab_q     <= stab_nxt;
               speed      <= speed_nxt;
               duplex     <= duplex_nxt;
               chg_pend_q <= (link_nxt != link_up) || (speed_nxt != speed) ||
                             (duplex_nxt != duplex);
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
